// File: rtl/bus_bridge_hs.sv
// bus_bridge_hs
//   Decouples the CPU memory stage from the SoC bus. CPU requests enter a
//   DEPTH-entry FIFO through a valid/ready handshake. They are issued to the
//   bus one at a time, and each issued transaction waits for bus_ready. A
//   transaction aborts after TIMEOUT cycles without bus_ready. Exactly one
//   registered response pulse is produced per accepted request, in request
//   order.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        CPU request handshake
//   req_write/addr/wdata       request payload (wdata stored as given)
//   resp_valid/rdata/err       one-cycle response pulse; rdata is 0 for
//                              writes and for timeouts
//   bus_valid/write/addr/wdata bus request, held stable while bus_valid=1
//   bus_ready/bus_rdata        slave completion and read data
//   busy                       FIFO non-empty or transaction in flight
//   err_count                  saturating count of timed-out transactions
module bus_bridge_hs #(
  parameter int AW      = 19,
  parameter int DW      = 19,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          resp_valid,
  output logic [DW-1:0] resp_rdata,
  output logic          resp_err,
  output logic          bus_valid,
  output logic          bus_write,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic          bus_ready,
  input  logic [DW-1:0] bus_rdata,
  output logic          busy,
  output logic [7:0]    err_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam int EW = 1 + AW + DW;

  typedef enum logic {ST_IDLE, ST_ISSUE} state_e;

  state_e        state_q, state_d;
  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [TW-1:0] wait_q, wait_d;
  logic          bus_write_q, bus_write_d;
  logic [AW-1:0] bus_addr_q, bus_addr_d;
  logic [DW-1:0] bus_wdata_q, bus_wdata_d;
  logic          resp_valid_q, resp_valid_d;
  logic          resp_err_q, resp_err_d;
  logic [DW-1:0] resp_rdata_q, resp_rdata_d;
  logic [7:0]    err_count_q, err_count_d;
  logic          push, pop, fifo_empty;
  logic [EW-1:0] head;

  assign req_ready  = (count_q != CW'(DEPTH));
  assign fifo_empty = (count_q == '0);
  assign push       = req_valid && req_ready;
  assign head       = mem_q[rd_ptr_q];

  // FIFO storage: no reset needed, occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {req_write, req_addr, req_wdata};
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    pop          = 1'b0;
    wait_d       = wait_q;
    bus_write_d  = bus_write_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;
    err_count_d  = err_count_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          wait_d  = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // Completion is checked first so bus_ready in the final wait cycle
        // still completes normally.
        if (bus_ready) begin
          resp_valid_d = 1'b1;
          resp_rdata_d = bus_write_q ? '0 : bus_rdata;
          if (!fifo_empty) begin
            pop    = 1'b1;          // back-to-back: bus_valid stays high
            wait_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (wait_q == TW'(TIMEOUT - 1)) begin
          // Abort via IDLE so bus_valid is low for exactly one cycle.
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
          state_d = ST_IDLE;
        end else begin
          wait_d = wait_q + TW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (pop) {bus_write_d, bus_addr_d, bus_wdata_d} = head;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      wait_q       <= '0;
      bus_write_q  <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      wait_q       <= wait_d;
      bus_write_q  <= bus_write_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      err_count_q  <= err_count_d;
    end
  end

  assign bus_valid  = (state_q == ST_ISSUE);
  assign bus_write  = bus_write_q;
  assign bus_addr   = bus_addr_q;
  assign bus_wdata  = bus_wdata_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign err_count  = err_count_q;
  assign busy       = !fifo_empty || (state_q == ST_ISSUE);

endmodule

// File: tb/tb_bus_bridge_hs.sv
// Testbench for bus_bridge_hs: directed table of single transactions,
// hand-written multi-cycle sequences (FIFO fill, reset mid-transaction), and
// a randomized run checked against a queue-based transaction model.
module tb_bus_bridge_hs;
  localparam int AW = 19;
  localparam int DW = 19;
  localparam int DEPTH = 4;
  localparam int TIMEOUT = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          resp_valid;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;
  logic          bus_valid;
  logic          bus_write;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic          bus_ready = 1'b0;
  logic [DW-1:0] bus_rdata = '0;
  logic          busy;
  logic [7:0]    err_count;

  bus_bridge_hs #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .bus_valid(bus_valid), .bus_write(bus_write), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rdata(bus_rdata),
    .busy(busy), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            delay;      // bus cycle index (0-based) where slave asserts bus_ready
    logic [DW-1:0] slave;
    int            exp_cycles; // bus_valid high cycles
    logic          exp_err;
    logic [DW-1:0] exp_rdata;
    logic [7:0]    exp_errs;
  } vec_t;
  vec_t tbl[6];

  task automatic run_vec(input int i);
    int t, first, nv, tresp, bad;
    logic got, rerr;
    logic [DW-1:0] rdat;
    @(negedge clk);
    req_valid = 1'b1; req_write = tbl[i].write;
    req_addr = tbl[i].addr; req_wdata = tbl[i].wdata;
    chk($sformatf("v%0d_req_ready", i), 32'(req_ready), 1);
    @(negedge clk);
    req_valid = 1'b0;
    t = 1; first = -1; nv = 0; got = 1'b0; tresp = 0; bad = 0; rerr = 1'b0; rdat = '0;
    while (t < 60 && !got) begin
      if (resp_valid) begin
        got = 1'b1; tresp = t; rerr = resp_err; rdat = resp_rdata;
      end
      if (bus_valid) begin
        if (first < 0) first = t;
        if (bus_addr !== tbl[i].addr || bus_write !== tbl[i].write ||
            (tbl[i].write && bus_wdata !== tbl[i].wdata)) bad++;
        bus_ready = (nv == tbl[i].delay);
        bus_rdata = tbl[i].slave;
        nv++;
      end else begin
        bus_ready = 1'b0;
      end
      if (!got) begin
        @(negedge clk);
        t++;
      end
    end
    bus_ready = 1'b0;
    chk($sformatf("v%0d_resp_seen", i), 32'(got), 1);
    chk($sformatf("v%0d_bus_stable", i), 32'(bad), 0);
    chk($sformatf("v%0d_issue_latency", i), 32'(first), 2);
    chk($sformatf("v%0d_bus_cycles", i), 32'(nv), 32'(tbl[i].exp_cycles));
    chk($sformatf("v%0d_resp_time", i), 32'(tresp), 32'(first + tbl[i].exp_cycles));
    chk($sformatf("v%0d_resp_err", i), 32'(rerr), 32'(tbl[i].exp_err));
    chk($sformatf("v%0d_resp_rdata", i), 32'(rdat), 32'(tbl[i].exp_rdata));
    chk($sformatf("v%0d_err_count", i), 32'(err_count), 32'(tbl[i].exp_errs));
    chk($sformatf("v%0d_busy", i), 32'(busy), 0);
  endtask

  // ---------------- randomized model ----------------
  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            delay;
  } req_t;
  req_t          issue_q[$];
  req_t          cur;
  logic          active = 1'b0;
  int            cyc = 0;
  logic          exp_rv = 1'b0, exp_err = 1'b0, expect_low = 1'b0;
  logic [DW-1:0] exp_rdata = '0;
  int            model_errs = 0;
  int            n_acc = 0, n_resp = 0;

  // Called once per cycle at the falling edge.
  task automatic step(input bit allow);
    logic [DW-1:0] rd;
    req_t r;
    int sel;
    // response and counter predicted in the previous cycle
    chk("rnd_resp_valid", 32'(resp_valid), 32'(exp_rv));
    if (exp_rv) begin
      chk("rnd_resp_err", 32'(resp_err), 32'(exp_err));
      chk("rnd_resp_rdata", 32'(resp_rdata), 32'(exp_rdata));
    end
    if (resp_valid) n_resp++;
    chk("rnd_err_count", 32'(err_count), 32'(model_errs));
    if (expect_low) chk("rnd_timeout_gap", 32'(bus_valid), 0);
    exp_rv = 1'b0; expect_low = 1'b0;
    // slave side
    if (bus_valid) begin
      if (!active) begin
        if (issue_q.size() == 0) begin
          chk("rnd_unexpected_bus_valid", 32'(bus_valid), 0);
        end else begin
          cur = issue_q.pop_front();
          active = 1'b1; cyc = 0;
        end
      end else begin
        cyc++;
      end
      if (active) begin
        chk("rnd_bus_addr", 32'(bus_addr), 32'(cur.addr));
        chk("rnd_bus_write", 32'(bus_write), 32'(cur.write));
        if (cur.write) chk("rnd_bus_wdata", 32'(bus_wdata), 32'(cur.wdata));
        rd = DW'($urandom);
        bus_rdata = rd;
        if (cyc == cur.delay) begin
          bus_ready = 1'b1;
          exp_rv = 1'b1; exp_err = 1'b0; exp_rdata = cur.write ? '0 : rd;
          active = 1'b0;
        end else begin
          bus_ready = 1'b0;
          if (cyc == TIMEOUT - 1) begin
            exp_rv = 1'b1; exp_err = 1'b1; exp_rdata = '0;
            if (model_errs < 255) model_errs++;
            active = 1'b0; expect_low = 1'b1;
          end
        end
      end
    end else begin
      if (active) begin
        chk("rnd_bus_valid_dropped", 32'(bus_valid), 1);
        active = 1'b0;
      end
      bus_ready = 1'($urandom);   // must be ignored while idle
      bus_rdata = DW'($urandom);
    end
    // request side
    if (allow) begin
      req_valid = ($urandom_range(0, 2) != 0);
      req_write = 1'($urandom);
      req_addr  = AW'($urandom);
      req_wdata = DW'($urandom);
    end else begin
      req_valid = 1'b0;
    end
    if (req_valid && req_ready) begin
      sel = $urandom_range(0, 9);
      if (sel < 5)       r.delay = $urandom_range(0, 3);
      else if (sel == 5) r.delay = TIMEOUT - 2;
      else if (sel == 6) r.delay = TIMEOUT - 1;
      else if (sel == 7) r.delay = TIMEOUT;
      else if (sel == 8) r.delay = 1000;
      else               r.delay = $urandom_range(4, 8);
      r.write = req_write; r.addr = req_addr; r.wdata = req_wdata;
      issue_q.push_back(r);
      n_acc++;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nbus, nresp;
    tbl[0] = '{1'b0, 19'h00123, 19'h00000, 0,    19'h4ABCD, 1,  1'b0, 19'h4ABCD, 8'd0};
    tbl[1] = '{1'b1, 19'h00010, 19'h7FFFF, 3,    19'h13579, 4,  1'b0, 19'h00000, 8'd0};
    tbl[2] = '{1'b0, 19'h00200, 19'h00000, 1000, 19'h11111, 16, 1'b1, 19'h00000, 8'd1};
    tbl[3] = '{1'b0, 19'h00300, 19'h00000, 15,   19'h55555, 16, 1'b0, 19'h55555, 8'd1};
    tbl[4] = '{1'b1, 19'h7FFFF, 19'h00001, 1000, 19'h22222, 16, 1'b1, 19'h00000, 8'd2};
    tbl[5] = '{1'b0, 19'h40000, 19'h00000, 14,   19'h7FFFF, 15, 1'b0, 19'h7FFFF, 8'd2};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_bus_valid", 32'(bus_valid), 0);
    chk("rst_req_ready", 32'(req_ready), 1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_bus_valid", 32'(bus_valid), 0);
    chk("rel_bus_addr", 32'(bus_addr), 0);
    chk("rel_resp_valid", 32'(resp_valid), 0);
    chk("rel_err_count", 32'(err_count), 0);
    chk("rel_req_ready", 32'(req_ready), 1);
    chk("rel_busy", 32'(busy), 0);

    for (int i = 0; i < 6; i++) run_vec(i);

    // FIFO fill with a stalled bus, then drain back-to-back
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0;
      req_addr = AW'(32'h400 + j); req_wdata = '0;
      chk($sformatf("fill_req_ready_%0d", j), 32'(req_ready), 1);
    end
    @(negedge clk);
    req_valid = 1'b0;
    chk("fill_full", 32'(req_ready), 0);
    chk("fill_busy", 32'(busy), 1);
    bus_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      chk($sformatf("b2b_bus_valid_%0d", j), 32'(bus_valid), 1);
      chk($sformatf("b2b_bus_addr_%0d", j), 32'(bus_addr), 32'h400 + j);
      bus_rdata = DW'(32'h100 + j);
      @(negedge clk);
      chk($sformatf("b2b_resp_valid_%0d", j), 32'(resp_valid), 1);
      chk($sformatf("b2b_resp_rdata_%0d", j), 32'(resp_rdata), 32'h100 + j);
      chk($sformatf("b2b_resp_err_%0d", j), 32'(resp_err), 0);
    end
    chk("b2b_idle_after", 32'(bus_valid), 0);
    bus_ready = 1'b0;

    // reset mid-ISSUE with two requests queued
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1;
      req_addr = AW'(32'h500 + j); req_wdata = DW'(32'h7000 + j);
    end
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_bus_valid", 32'(bus_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_bus_valid", 32'(bus_valid), 0);
    chk("arst_bus_write", 32'(bus_write), 0);
    chk("arst_bus_addr", 32'(bus_addr), 0);
    chk("arst_bus_wdata", 32'(bus_wdata), 0);
    chk("arst_err_count", 32'(err_count), 0);
    chk("arst_req_ready", 32'(req_ready), 1);
    chk("arst_busy", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus_ready = 1'b1;
    nbus = 0; nresp = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus_valid) nbus++;
      if (resp_valid) nresp++;
    end
    chk("post_rst_bus_cycles", 32'(nbus), 0);
    chk("post_rst_resp_count", 32'(nresp), 0);
    chk("post_rst_req_ready", 32'(req_ready), 1);
    bus_ready = 1'b0;

    // randomized traffic against the transaction model
    model_errs = 0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      step(1'b1);
    end
    for (int c = 0; c < 2000 && (issue_q.size() != 0 || active || exp_rv); c++) begin
      @(negedge clk);
      step(1'b0);
    end
    chk("rnd_drained", 32'(issue_q.size()), 0);
    chk("rnd_resp_count", 32'(n_resp), 32'(n_acc));
    bus_ready = 1'b0;
    @(negedge clk);
    chk("rnd_final_busy", 32'(busy), 0);
    chk("rnd_final_req_ready", 32'(req_ready), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
